// File: rtl/aes64_ctrl.sv
// AES-128 encrypt sequencer over an external aes64 datapath: 61 cycles per block with a 1-cycle datapath, stalls on dp_ready,
// holds the result in DONE until out_ready. Define AES64_CTRL_KEYOUT_EN to expose each round key (rk_valid/rk_round/rk_key).
module aes64_ctrl (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         dp_valid,
  output logic         dp_hi,
  output logic         dp_mix,
  output logic         dp_op_enc,
  output logic         dp_op_dec,
  output logic         dp_op_imix,
  output logic         dp_op_ks1,
  output logic         dp_op_ks2,
  output logic [63:0]  dp_rs1,
  output logic [63:0]  dp_rs2,
  input  logic [63:0]  dp_rd,
  input  logic         dp_ready
`ifdef AES64_CTRL_KEYOUT_EN
  ,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_key
`endif
);

  typedef enum logic [2:0] {IDLE, KS1, KS2L, KS2H, ENCL, ENCH, ADDK, DONE} state_t;

  typedef struct packed {
    logic        valid;
    logic        hi;
    logic        mix;
    logic        enc;
    logic        ks1;
    logic        ks2;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } dp_cmd_t;

  state_t      state;
  dp_cmd_t     cmd;
  logic [63:0] s0, s1, k0, k1, t;
  logic [3:0]  rnd;

  function automatic dp_cmd_t mk_cmd(input logic ks1, input logic ks2, input logic mix,
                                     input logic [63:0] rs1, input logic [63:0] rs2);
    dp_cmd_t c;
    c.valid = 1'b1;
    c.hi    = 1'b0;
    c.mix   = mix;
    c.enc   = !(ks1 || ks2);
    c.ks1   = ks1;
    c.ks2   = ks2;
    c.rs1   = rs1;
    c.rs2   = rs2;
    return c;
  endfunction

  // The datapath command is registered and only rewritten on a state change,
  // so it holds steady for however long dp_ready stays low.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state     <= IDLE;
      cmd       <= '0;
      s0        <= '0;
      s1        <= '0;
      k0        <= '0;
      k1        <= '0;
      t         <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef AES64_CTRL_KEYOUT_EN
      rk_valid  <= 1'b0;
      rk_round  <= '0;
      rk_key    <= '0;
`endif
    end else begin
`ifdef AES64_CTRL_KEYOUT_EN
      rk_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            {s1, s0} <= in_pt ^ in_key;
            {k1, k0} <= in_key;
            rnd      <= 4'd1;
            cmd      <= mk_cmd(1'b1, 1'b0, 1'b0, in_key[127:64], 64'd0);
            in_ready <= 1'b0;
            state    <= KS1;
          end
        end
        KS1: begin
          if (dp_ready) begin
            t     <= dp_rd;
            cmd   <= mk_cmd(1'b0, 1'b1, 1'b0, dp_rd, k0);
            state <= KS2L;
          end
        end
        KS2L: begin
          // The high key half is derived from the freshly updated k0.
          if (dp_ready) begin
            k0    <= dp_rd;
            cmd   <= mk_cmd(1'b0, 1'b1, 1'b0, dp_rd, k1);
            state <= KS2H;
          end
        end
        KS2H: begin
          if (dp_ready) begin
            k1    <= dp_rd;
            cmd   <= mk_cmd(1'b0, 1'b0, rnd != 4'd10, s0, s1);
            state <= ENCL;
          end
        end
        ENCL: begin
          if (dp_ready) begin
            t      <= dp_rd;
            cmd.hi <= 1'b1;
            state  <= ENCH;
          end
        end
        ENCH: begin
          if (dp_ready) begin
            s1    <= dp_rd;
            s0    <= t;
            cmd   <= '0;
            state <= ADDK;
`ifdef AES64_CTRL_KEYOUT_EN
            rk_valid <= 1'b1;
            rk_round <= rnd;
            rk_key   <= {k1, k0};
`endif
          end
        end
        ADDK: begin
          s1 <= s1 ^ k1;
          s0 <= s0 ^ k0;
          if (rnd == 4'd10) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd   <= rnd + 4'd1;
            cmd   <= mk_cmd(1'b1, 1'b0, 1'b0, k1, {60'd0, rnd});
            state <= KS1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cmd       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign dp_valid   = cmd.valid;
  assign dp_hi      = cmd.hi;
  assign dp_mix     = cmd.mix;
  assign dp_op_enc  = cmd.enc;
  assign dp_op_ks1  = cmd.ks1;
  assign dp_op_ks2  = cmd.ks2;
  assign dp_op_dec  = 1'b0;
  assign dp_op_imix = 1'b0;
  assign dp_rs1     = cmd.rs1;
  assign dp_rs2     = cmd.rs2;
  assign out_ct     = {s1, s0};

endmodule

// File: tb/tb_aes64_ctrl.sv
// Bench for aes64_ctrl: behavioural aes64 datapath responder plus a byte-level AES-128 reference model.
module tb_aes64_ctrl;

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_pt, in_key, out_ct;
  logic         dp_valid, dp_hi, dp_mix, dp_op_enc, dp_op_dec, dp_op_imix, dp_op_ks1, dp_op_ks2;
  logic [63:0]  dp_rs1, dp_rs2, dp_rd;
  logic         dp_ready;
`ifdef AES64_CTRL_KEYOUT_EN
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_key;
  int           rk_pulses;
  logic [127:0] rk_last;
`endif

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  int         total = 0;
  int         bad = 0;
  int         wait_total;
  int         dp_delay_mode;
  bit         armed;
  logic [7:0] sbox [256];

  always #5 g_clk = ~g_clk;

  aes64_ctrl dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .dp_valid(dp_valid), .dp_hi(dp_hi), .dp_mix(dp_mix), .dp_op_enc(dp_op_enc),
    .dp_op_dec(dp_op_dec), .dp_op_imix(dp_op_imix), .dp_op_ks1(dp_op_ks1), .dp_op_ks2(dp_op_ks2),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd), .dp_ready(dp_ready)
`ifdef AES64_CTRL_KEYOUT_EN
    , .rk_valid(rk_valid), .rk_round(rk_round), .rk_key(rk_key)
`endif
  );

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox[w[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = w;
    return {gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02),
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3};
  endfunction

  // Behaviour of the aes64 datapath ops the controller is allowed to issue.
  function automatic logic [63:0] dp_model(input logic enc, input logic ks1, input logic hi, input logic mix,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] st, sr;
    logic [63:0]  h;
    logic [31:0]  w, w0;
    logic [7:0]   rc;
    if (ks1) begin
      rc = 8'h01;
      for (int i = 0; i < int'(b[3:0]); i++) rc = xt(rc);
      w = a[63:32];
      if (b[3:0] != 4'hA) w = {w[7:0], w[31:8]};
      w = sub32(w) ^ {24'd0, rc};
      return {w, w};
    end else if (enc) begin
      st = {b, a};
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) sr[8*(4*c+r) +: 8] = st[8*(4*((c+r)%4)+r) +: 8];
      h = hi ? sr[127:64] : sr[63:0];
      h = {sub32(h[63:32]), sub32(h[31:0])};
      if (mix) h = {mix_col(h[63:32]), mix_col(h[31:0])};
      return h;
    end else begin
      w0 = a[63:32] ^ b[31:0];
      return {w0 ^ b[63:32], w0};
    end
  endfunction

  // Reference AES-128 on a byte array with a plain word key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub32({t[7:0], t[31:8]}) ^ {24'd0, rc};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) st[j] = pt[8*j +: 8] ^ key[8*j +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) sh[j] = sbox[st[4*(((j/4) + (j%4)) % 4) + j%4]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) {st[4*c+3], st[4*c+2], st[4*c+1], st[4*c]} =
            mix_col({sh[4*c+3], sh[4*c+2], sh[4*c+1], sh[4*c]});
        else for (int j = 0; j < 4; j++) st[4*c+j] = sh[4*c+j];
      end
      for (int j = 0; j < 16; j++) st[j] = st[j] ^ w[4*r + j/4][8*(j%4) +: 8];
    end
    for (int j = 0; j < 16; j++) ct[8*j +: 8] = st[j];
    return ct;
  endfunction

  function automatic logic [134:0] dp_vec();
    return {dp_hi, dp_mix, dp_op_enc, dp_op_dec, dp_op_imix, dp_op_ks1, dp_op_ks2, dp_rs1, dp_rs2};
  endfunction

  task automatic dp_responder();
    int           wcnt, target;
    bit           busy;
    logic [134:0] held;
    busy = 1'b0; wcnt = 0; target = 0; held = '0;
    forever begin
      @(negedge g_clk);
      if (!armed) begin
        dp_ready = 1'b0;
        busy     = 1'b0;
      end else if (dp_valid !== 1'b1) begin
        check("dp_idle_zero", dp_vec(), 0);
        dp_ready = 1'b0;
        busy     = 1'b0;
      end else begin
        if (!busy) begin
          busy   = 1'b1;
          wcnt   = 0;
          held   = dp_vec();
          target = (dp_delay_mode < 0) ? int'($urandom_range(3, 0)) : dp_delay_mode;
          check("dp_onehot", $countones({dp_op_enc, dp_op_dec, dp_op_imix, dp_op_ks1, dp_op_ks2}), 1);
          check("dp_dec_imix", {dp_op_dec, dp_op_imix}, 0);
        end else begin
          check("dp_stable", dp_vec(), held);
        end
        if (wcnt >= target) begin
          dp_ready = 1'b1;
          dp_rd    = dp_model(dp_op_enc, dp_op_ks1, dp_hi, dp_mix, dp_rs1, dp_rs2);
          busy     = 1'b0;
        end else begin
          dp_ready = 1'b0;
          dp_rd    = {$urandom, $urandom};
          wcnt++;
          wait_total++;
        end
      end
`ifdef AES64_CTRL_KEYOUT_EN
      if (armed && rk_valid === 1'b1) begin
        rk_pulses++;
        if (rk_round == 4'd10) rk_last = rk_key;
      end
`endif
    end
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int hold, input string tag);
    int           lat, w0;
    logic [127:0] exp_ct;
`ifdef AES64_CTRL_KEYOUT_EN
    int           rk0;
    rk0 = rk_pulses;
`endif
    exp_ct = aes_ref(pt, key);
    w0     = wait_total;
    check({tag, "_ready"}, in_ready, 1);
    in_pt     = pt;
    in_key    = key;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge g_clk);
    lat = 1;
    @(negedge g_clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    while (out_valid !== 1'b1 && lat < 3000) begin
      @(posedge g_clk);
      lat++;
      @(negedge g_clk);
    end
    check({tag, "_lat"}, lat, 61 + (wait_total - w0));
    check({tag, "_ct"}, out_ct, exp_ct);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_pt    = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge g_clk);
      @(negedge g_clk);
      check({tag, "_hold_ct"}, out_ct, exp_ct);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_out_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    check({tag, "_post_out_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
`ifdef AES64_CTRL_KEYOUT_EN
    check({tag, "_rk_pulses"}, rk_pulses - rk0, 10);
`endif
  endtask

  initial begin
    int ench, guard;
    g_resetn = 1'b0; in_valid = 1'b0; in_pt = '0; in_key = '0; out_ready = 1'b1;
    dp_ready = 1'b0; dp_rd = '0; armed = 1'b0; dp_delay_mode = 0; wait_total = 0;
`ifdef AES64_CTRL_KEYOUT_EN
    rk_pulses = 0; rk_last = '0;
`endif
    for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
    fork
      dp_responder();
    join_none

    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dp_valid", dp_valid, 0);
    check("rst_out_ct", out_ct, 0);
    check("rst_dp_cmd", dp_vec(), 0);
    armed    = 1'b1;
    g_resetn = 1'b1;

    run_block(C1_PT, C1_KEY, 0, "c1");
    check("c1_known_ct", out_ct, C1_CT);
`ifdef AES64_CTRL_KEYOUT_EN
    // FIPS-197 C.1 round-10 key 13111d7f... with byte 0 in the low bits
    check("c1_rk10", rk_last, 128'hc5302b4d8ba707f3174a94e37f1d1113);
`endif

    dp_delay_mode = 3;
    run_block(C1_PT, C1_KEY, 0, "c1_wait3");
    check("c1_wait3_waits", wait_total, 150);
    dp_delay_mode = 0;

    run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 20, "hold");
    run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, "b2b");

    // Abort mid-block: reset during the round-5 high-half encrypt op.
    in_pt = C1_PT; in_key = C1_KEY; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    ench = 0; guard = 0;
    while (ench < 5 && guard < 500) begin
      if (dp_valid === 1'b1 && dp_op_enc === 1'b1 && dp_hi === 1'b1) ench++;
      if (ench < 5) begin
        @(negedge g_clk);
        guard++;
      end
    end
    check("abort_found_r5_ench", ench, 5);
    g_resetn = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_dp_valid", dp_valid, 0);
    check("abort_out_ct", out_ct, 0);
    g_resetn = 1'b1;
    run_block(C1_PT, C1_KEY, 0, "c1_after_abort");

    dp_delay_mode = -1;
    for (int n = 0; n < 4; n++)
      run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                (n == 2) ? 3 : 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
